// File: rtl/bs_write_arb.sv
// Banked-store write-port arbiter: grants refill (d) or release (c) per burst and tracks beat order.
// Compile-time option BS_WRITE_ARB_RR_EN enables round-robin priority per burst; default is static d-first.
module bs_write_arb #(
    parameter int WAY_W  = 3,
    parameter int SET_W  = 10,
    parameter int BEAT_W = 3,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_adr_valid,
    output logic              d_adr_ready,
    input  logic              d_adr_noop,
    input  logic [WAY_W-1:0]  d_adr_way,
    input  logic [SET_W-1:0]  d_adr_set,
    input  logic [BEAT_W-1:0] d_adr_beat,
    input  logic              d_adr_last,
    input  logic [DATA_W-1:0] d_dat_data,
    input  logic              c_adr_valid,
    output logic              c_adr_ready,
    input  logic              c_adr_noop,
    input  logic [WAY_W-1:0]  c_adr_way,
    input  logic [SET_W-1:0]  c_adr_set,
    input  logic [BEAT_W-1:0] c_adr_beat,
    input  logic              c_adr_last,
    input  logic [DATA_W-1:0] c_dat_data,
    output logic              bs_adr_valid,
    input  logic              bs_adr_ready,
    output logic              bs_adr_noop,
    output logic [WAY_W-1:0]  bs_adr_way,
    output logic [SET_W-1:0]  bs_adr_set,
    output logic [BEAT_W-1:0] bs_adr_beat,
    output logic [DATA_W-1:0] bs_dat_data,
    output logic              bs_src,
    output logic              err_beat
);

    typedef enum logic [1:0] {IDLE, LOCK_D, LOCK_C} state_t;

    state_t            state;
    logic [BEAT_W-1:0] exp_beat;
    logic              pri;
    logic              grant_c;
    logic              fire;
    logic              cur_last;

`ifdef BS_WRITE_ARB_RR_EN
    logic pri_q;
    logic contend_q;
    logic contended;
    assign pri = pri_q;
    // Contention is judged on the burst's first (IDLE) cycle only.
    assign contended = (state == IDLE) ? (d_adr_valid & c_adr_valid) : contend_q;
`else
    assign pri = 1'b0;
`endif

    always_comb begin
        grant_c = 1'b0;
        unique case (state)
            LOCK_D:  grant_c = 1'b0;
            LOCK_C:  grant_c = 1'b1;
            default: grant_c = (d_adr_valid & c_adr_valid) ? pri : c_adr_valid;
        endcase
    end

    assign bs_src       = grant_c;
    assign bs_adr_valid = grant_c ? c_adr_valid : d_adr_valid;
    assign bs_adr_noop  = grant_c ? c_adr_noop  : d_adr_noop;
    assign bs_adr_way   = grant_c ? c_adr_way   : d_adr_way;
    assign bs_adr_set   = grant_c ? c_adr_set   : d_adr_set;
    assign bs_adr_beat  = grant_c ? c_adr_beat  : d_adr_beat;
    assign bs_dat_data  = grant_c ? c_dat_data  : d_dat_data;
    assign cur_last     = grant_c ? c_adr_last  : d_adr_last;

    assign fire        = bs_adr_valid & bs_adr_ready;
    assign d_adr_ready = fire & ~grant_c;
    assign c_adr_ready = fire & grant_c;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            exp_beat <= '0;
            err_beat <= 1'b0;
`ifdef BS_WRITE_ARB_RR_EN
            pri_q     <= 1'b0;
            contend_q <= 1'b0;
`endif
        end else if (fire) begin
            // Out-of-order beats are flagged but still forwarded untouched.
            if (state != IDLE && bs_adr_beat != exp_beat)
                err_beat <= 1'b1;
            if (cur_last) begin
                state <= IDLE;
`ifdef BS_WRITE_ARB_RR_EN
                if (contended)
                    pri_q <= ~grant_c;
`endif
            end else begin
                state    <= grant_c ? LOCK_C : LOCK_D;
                exp_beat <= (state == IDLE) ? bs_adr_beat + BEAT_W'(1) : exp_beat + BEAT_W'(1);
`ifdef BS_WRITE_ARB_RR_EN
                if (state == IDLE)
                    contend_q <= d_adr_valid & c_adr_valid;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bs_write_arb.sv
// Directed bench for bs_write_arb: arbitration, locking, bubbles, stalls, beat-order errors and reset.
module tb_bs_write_arb;

    localparam logic [63:0] D_BASE = 64'hD0D0_0000_0000_0000;
    localparam logic [63:0] C_BASE = 64'hC0C0_0000_0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        d_adr_valid, d_adr_ready, d_adr_noop, d_adr_last;
    logic [2:0]  d_adr_way, d_adr_beat;
    logic [9:0]  d_adr_set;
    logic [63:0] d_dat_data;
    logic        c_adr_valid, c_adr_ready, c_adr_noop, c_adr_last;
    logic [2:0]  c_adr_way, c_adr_beat;
    logic [9:0]  c_adr_set;
    logic [63:0] c_dat_data;
    logic        bs_adr_valid, bs_adr_ready, bs_adr_noop, bs_src, err_beat;
    logic [2:0]  bs_adr_way, bs_adr_beat;
    logic [9:0]  bs_adr_set;
    logic [63:0] bs_dat_data;

    int n_cmp = 0;
    int n_err = 0;

    bs_write_arb dut (
        .clock(clock), .reset(reset),
        .d_adr_valid(d_adr_valid), .d_adr_ready(d_adr_ready), .d_adr_noop(d_adr_noop),
        .d_adr_way(d_adr_way), .d_adr_set(d_adr_set), .d_adr_beat(d_adr_beat),
        .d_adr_last(d_adr_last), .d_dat_data(d_dat_data),
        .c_adr_valid(c_adr_valid), .c_adr_ready(c_adr_ready), .c_adr_noop(c_adr_noop),
        .c_adr_way(c_adr_way), .c_adr_set(c_adr_set), .c_adr_beat(c_adr_beat),
        .c_adr_last(c_adr_last), .c_dat_data(c_dat_data),
        .bs_adr_valid(bs_adr_valid), .bs_adr_ready(bs_adr_ready), .bs_adr_noop(bs_adr_noop),
        .bs_adr_way(bs_adr_way), .bs_adr_set(bs_adr_set), .bs_adr_beat(bs_adr_beat),
        .bs_dat_data(bs_dat_data), .bs_src(bs_src), .err_beat(err_beat)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drv_d(input logic v, input logic [2:0] b, input logic l);
        d_adr_valid = v; d_adr_beat = b; d_adr_last = l; d_dat_data = D_BASE | 64'(b);
    endtask

    task automatic drv_c(input logic v, input logic [2:0] b, input logic l);
        c_adr_valid = v; c_adr_beat = b; c_adr_last = l; c_dat_data = C_BASE | 64'(b);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; bs_adr_ready = 1'b1;
        d_adr_noop = 1'b0; d_adr_way = 3'h1; d_adr_set = 10'h011;
        c_adr_noop = 1'b1; c_adr_way = 3'h6; c_adr_set = 10'h3a5;
        drv_d(0, 0, 0); drv_c(0, 0, 0);
        repeat (2) @(posedge clock);
        tick(); reset = 1'b0; #1;
        chk("rst_bs_valid", bs_adr_valid, 0);
        chk("rst_d_ready", d_adr_ready, 0);
        chk("rst_c_ready", c_adr_ready, 0);
        chk("rst_err", err_beat, 0);

        // Single requester d, 8-beat burst
        for (int i = 0; i < 8; i++) begin
            drv_d(1, 3'(i), i == 7); #1;
            chk("t1_d_ready", d_adr_ready, 1);
            chk("t1_src", bs_src, 0);
            chk("t1_beat", bs_adr_beat, 64'(i));
            chk("t1_data", bs_dat_data, D_BASE | 64'(i));
            chk("t1_way", bs_adr_way, 3'h1);
            tick();
        end
        drv_d(0, 0, 0); #1;
        chk("t1_err", err_beat, 0);

        // Contention: d wins, c waits, then c follows with no gap
        for (int i = 0; i < 8; i++) begin
            drv_d(1, 3'(i), i == 7); drv_c(1, 0, 0); #1;
            chk("t2_d_ready", d_adr_ready, 1);
            chk("t2_c_ready", c_adr_ready, 0);
            chk("t2_src", bs_src, 0);
            tick();
        end
        drv_d(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drv_c(1, 3'(i), i == 7); #1;
            chk("t2c_c_ready", c_adr_ready, 1);
            chk("t2c_src", bs_src, 1);
            chk("t2c_set", bs_adr_set, 10'h3a5);
            chk("t2c_noop", bs_adr_noop, 1);
            tick();
        end
        // Fresh contention with the store stalled: priority depends on build
        bs_adr_ready = 1'b0; drv_d(1, 0, 0); drv_c(1, 0, 0); #1;
`ifdef BS_WRITE_ARB_RR_EN
        chk("t2_pri_src", bs_src, 1);
`else
        chk("t2_pri_src", bs_src, 0);
`endif
        chk("t2_stall_d_ready", d_adr_ready, 0);
        tick(); bs_adr_ready = 1'b1;

        // c locked at beat 3, drops valid for 2 cycles while d is valid
        drv_d(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drv_c(1, 3'(i), 0); #1;
            chk("t3_c_ready", c_adr_ready, 1);
            tick();
        end
        drv_c(0, 4, 0); drv_d(1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t3_bubble_valid", bs_adr_valid, 0);
            chk("t3_bubble_d_ready", d_adr_ready, 0);
            chk("t3_bubble_src", bs_src, 1);
            tick();
        end
        for (int i = 4; i < 8; i++) begin
            drv_c(1, 3'(i), i == 7); #1;
            chk("t3_resume_c_ready", c_adr_ready, 1);
            chk("t3_resume_d_ready", d_adr_ready, 0);
            tick();
        end
        drv_c(0, 0, 0); drv_d(0, 0, 0); #1;
        chk("t3_err", err_beat, 0);

        // Stall of 3 cycles mid-burst: grant and expected beat unchanged
        for (int i = 0; i < 2; i++) begin
            drv_d(1, 3'(i), 0); #1;
            chk("t5_d_ready", d_adr_ready, 1);
            tick();
        end
        bs_adr_ready = 1'b0; drv_d(1, 2, 0); drv_c(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stall_d_ready", d_adr_ready, 0);
            chk("t5_stall_c_ready", c_adr_ready, 0);
            chk("t5_stall_src", bs_src, 0);
            chk("t5_stall_valid", bs_adr_valid, 1);
            tick();
        end
        bs_adr_ready = 1'b1; drv_c(0, 0, 0);
        for (int i = 2; i < 8; i++) begin
            drv_d(1, 3'(i), i == 7); #1;
            chk("t5_resume_d_ready", d_adr_ready, 1);
            tick();
        end
        drv_d(0, 0, 0); #1;
        chk("t5_err", err_beat, 0);

        // Beat 5 presented when 4 is expected
        for (int i = 0; i < 4; i++) begin
            drv_d(1, 3'(i), 0); tick();
        end
        drv_d(1, 5, 0); #1;
        chk("t4_err_before", err_beat, 0);
        chk("t4_fwd_beat", bs_adr_beat, 5);
        tick(); drv_d(1, 6, 0); #1;
        chk("t4_err_rise", err_beat, 1);
        tick(); drv_d(1, 7, 1); tick(); drv_d(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1; chk("t4_err_sticky", err_beat, 1); tick();
        end

        // Reset during beat 2 of a c burst
        for (int i = 0; i < 2; i++) begin
            drv_c(1, 3'(i), 0); tick();
        end
        drv_c(1, 2, 0); reset = 1'b1; tick();
        reset = 1'b0; drv_c(1, 0, 0); drv_d(1, 0, 0); #1;
        chk("t6_src", bs_src, 0);
        chk("t6_d_ready", d_adr_ready, 1);
        chk("t6_c_ready", c_adr_ready, 0);
        chk("t6_err", err_beat, 0);
        tick(); drv_d(0, 0, 0); drv_c(0, 0, 0); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
